// File: rtl/fifo128_arb_pkg.sv
// fifo128_arb_pkg: shared state encoding and default widths for the FIFO write arbiter
package fifo128_arb_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    localparam int DW      = 128;
    localparam int CNT_W   = 32;
    localparam int BURST_W = 8;
endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational rotating-priority picker, first set req bit at or after ptr
module fifo_rr_pick
    import fifo128_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);
    // scan from the farthest offset down so the offset nearest ptr wins
    always_comb begin
        int idx;
        pick  = '0;
        valid = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            idx = (idx >= N_REQ) ? idx - N_REQ : idx;
            if (req[idx]) pick = N_REQ'(1) << idx;
        end
    end
endmodule

// File: rtl/fifo128_wr_arbiter.sv
// fifo128_wr_arbiter: round-robin burst-capped arbiter for the shared 128-bit FIFO write port
module fifo128_wr_arbiter
    import fifo128_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = fifo128_arb_pkg::DW,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    grant,
    input  logic                fifo_full,
    output logic [DW-1:0]       fifo_wdata,
    output logic                fifo_wreq,
    output logic [CNT_W-1:0]    word_cnt,
    output logic                busy
);
    localparam int PW = $clog2(N_REQ);

    state_t             state, state_nx;
    logic [PW-1:0]      ptr, owner, pick_idx;
    logic [N_REQ-1:0]   pick;
    logic               pick_vld, accept, rel;
    logic [BURST_W-1:0] burst_cnt;

    fifo_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    // index of the picked requester, kept alongside the one-hot grant for muxing
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) if (pick[i]) pick_idx = PW'(i);
    end

    // owner's accept is purely combinational so words stream back-to-back
    always_comb begin
        busy       = state == ST_GRANT;
        accept     = busy && req[owner] && !fifo_full;
        rel        = busy && (!req[owner] || (accept && burst_cnt == BURST_W'(MAX_BURST - 1)));
        ack        = accept ? grant : '0;
        fifo_wreq  = accept;
        fifo_wdata = busy ? req_data[owner*DW +: DW] : '0;
    end

    // next state: grant on any request, return to idle on release
    always_comb begin
        state_nx = (state == ST_IDLE) ? (pick_vld ? ST_GRANT : ST_IDLE) : (rel ? ST_IDLE : ST_GRANT);
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_nx;
    end

    // grant, rotation pointer and word/burst counters
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            word_cnt  <= '0;
        end else begin
            if (accept) begin
                word_cnt  <= word_cnt + 1'b1;
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (state == ST_IDLE && pick_vld) begin
                grant <= pick;
                owner <= pick_idx;
            end
            if (rel) begin
                grant     <= '0;
                burst_cnt <= '0;
                ptr       <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end
endmodule
